fetch_entry_fifo: RTL and testbench



---
 rtl/fetch_entry_fifo.sv | 63 ++++++
 tb/tb_fetch_entry_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_fifo.sv
// fetch_entry_fifo: in-order fetch-entry buffer between the realigner and the ID stage.
// Define FETCH_FIFO_BYPASS_EN to present an entry arriving at an empty FIFO in the same cycle.
module fetch_entry_fifo #(
    parameter int unsigned ENTRY_W = 64,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] in_entry_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [ENTRY_W-1:0] fetch_entry_o,
    output logic               fetch_entry_valid_o,
    input  logic               fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0] count;
    logic bypass, push, pop, write, advance;

`ifdef FETCH_FIFO_BYPASS_EN
    // reset is excluded so nothing is presented while the FIFO is being cleared
    assign bypass = count == '0 && in_valid_i && !flush_i && !rst_i;
    assign fetch_entry_o = bypass ? in_entry_i : mem[rptr];
`else
    assign bypass = 1'b0;
    assign fetch_entry_o = mem[rptr];
`endif

    assign count_o             = count;
    assign in_ready_o          = count != FULL;
    assign fetch_entry_valid_o = count != '0 || bypass;
    assign push    = in_valid_i && in_ready_o && !flush_i;
    assign pop     = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;
    // an entry consumed straight from the input never touches storage
    assign write   = push && !(bypass && fetch_entry_ready_i);
    assign advance = pop && !bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (write) begin
                mem[wptr] <= in_entry_i;
                wptr      <= wptr + AW'(1);
            end
            if (advance) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(write) - (AW+1)'(advance);
        end
    end
endmodule

// File: tb/tb_fetch_entry_fifo.sv
// tb_fetch_entry_fifo: vector table, directed corner cases and a random run against a queue model.
module tb_fetch_entry_fifo;
    localparam int DEPTH = 4;
`ifdef FETCH_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, fetch_valid, fetch_ready;
    logic [63:0] in_entry, fetch_entry;
    logic [2:0]  count;

    int tests = 0;
    int errs  = 0;
    bit mon   = 1'b0;
    logic [63:0] q[$];
    logic mbyp;
    int msz;

    fetch_entry_fifo #(.ENTRY_W(64), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_entry_i(in_entry), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .fetch_entry_o(fetch_entry), .fetch_entry_valid_o(fetch_valid),
        .fetch_entry_ready_i(fetch_ready), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // entries are {address, instruction}
    function automatic logic [63:0] w(input int n);
        return {32'h8000_0000 + 32'(4 * n), 32'h0010_0093 + 32'(n)};
    endfunction

    task automatic drv(input bit r, input bit f, input bit iv, input logic [63:0] e, input bit rd);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_entry = e; fetch_ready = rd;
        #1;
    endtask

    // reference: expected outputs from queue occupancy, sampled mid-cycle
    always begin
        @(negedge clk);
        #2;
        if (mon) begin
            msz  = q.size();
            mbyp = BYP && msz == 0 && in_valid && !flush && !rst;
            chk("m_count", 64'(count), 64'(msz));
            chk("m_in_ready", 64'(in_ready), 64'(msz != DEPTH));
            chk("m_valid", 64'(fetch_valid), 64'(msz != 0 || mbyp));
            if (msz != 0) chk("m_entry", fetch_entry, q[0]);
            else if (mbyp) chk("m_bypass_entry", fetch_entry, in_entry);
        end
    end

    always @(posedge clk) begin
        if (mon) begin
            if (rst || flush) q.delete();
            else if (!(BYP && q.size() == 0 && in_valid && fetch_ready)) begin
                msz = q.size();
                if (msz != 0 && fetch_ready) void'(q.pop_front());
                if (in_valid && msz < DEPTH) q.push_back(in_entry);
            end
        end
    end

    typedef struct {
        bit rst, iv, rdy;
        logic [63:0] ent;
        bit cv, ev, ce;
        logic [63:0] ee;
        logic [2:0] ec;
        bit er;
    } vec_t;

    function automatic vec_t mk(bit r, bit iv, bit rd, logic [63:0] e, bit cv, bit ev, bit ce,
                                logic [63:0] ee, int ec, bit er);
        vec_t v;
        v.rst = r; v.iv = iv; v.rdy = rd; v.ent = e; v.cv = cv; v.ev = ev; v.ce = ce;
        v.ee = ee; v.ec = 3'(ec); v.er = er;
        return v;
    endfunction

    vec_t vec[13];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_entry = '0; fetch_ready = 1'b0;
        @(posedge clk);
        #1 mon = 1'b1;

        // reset held with valid input, then fill past full, then drain in order
        for (int i = 0; i < 3; i++) vec[i] = mk(1, 1, 0, w(0), 1, 0, 1, 64'h0, 0, 1);
        vec[3]  = mk(0, 1, 0, w(0), 0, 0, 0, 64'h0, 0, 1);
        vec[4]  = mk(0, 1, 0, w(1), 1, 1, 1, w(0), 1, 1);
        vec[5]  = mk(0, 1, 0, w(2), 1, 1, 1, w(0), 2, 1);
        vec[6]  = mk(0, 1, 0, w(3), 1, 1, 1, w(0), 3, 1);
        vec[7]  = mk(0, 1, 0, w(4), 1, 1, 1, w(0), 4, 0);
        vec[8]  = mk(0, 0, 1, w(9), 1, 1, 1, w(0), 4, 0);
        vec[9]  = mk(0, 0, 1, w(9), 1, 1, 1, w(1), 3, 1);
        vec[10] = mk(0, 0, 1, w(9), 1, 1, 1, w(2), 2, 1);
        vec[11] = mk(0, 0, 1, w(9), 1, 1, 1, w(3), 1, 1);
        vec[12] = mk(0, 0, 1, w(9), 1, 0, 0, 64'h0, 0, 1);
        foreach (vec[i]) begin
            drv(vec[i].rst, 0, vec[i].iv, vec[i].ent, vec[i].rdy);
            chk($sformatf("t%0d_count", i), 64'(count), 64'(vec[i].ec));
            chk($sformatf("t%0d_in_ready", i), 64'(in_ready), 64'(vec[i].er));
            if (vec[i].cv) chk($sformatf("t%0d_valid", i), 64'(fetch_valid), 64'(vec[i].ev));
            if (vec[i].ce) chk($sformatf("t%0d_entry", i), fetch_entry, vec[i].ee);
        end

        // wrap-around: one stored, ten push+pop cycles
        drv(0, 0, 1, w(100), 0);
        for (int k = 1; k <= 10; k++) begin
            drv(0, 0, 1, w(100 + k), 1);
            chk("wrap_count", 64'(count), 64'd1);
            chk("wrap_valid", 64'(fetch_valid), 64'd1);
            chk("wrap_entry", fetch_entry, w(100 + k - 1));
        end
        drv(0, 0, 0, '0, 1);

        // back-pressure: head must hold while stalled
        drv(0, 0, 1, {32'h8000_0100, 32'h0000_0013}, 0);
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 1, w(200 + k), 0);
            chk("bp_valid", 64'(fetch_valid), 64'd1);
            chk("bp_instr", 64'(fetch_entry[31:0]), 64'h13);
        end
        drv(0, 1, 0, '0, 0);

        // flush with simultaneous push and pop
        drv(0, 0, 1, w(300), 0);
        drv(0, 0, 1, w(301), 0);
        drv(0, 0, 1, w(302), 0);
        drv(0, 1, 1, w(303), 1);
        chk("fl_count_before", 64'(count), 64'd3);
        drv(0, 0, 1, {32'h8000_1000, 32'h0000_0013}, 0);
        chk("fl_count_after", 64'(count), 64'd0);
        chk("fl_valid_after", 64'(fetch_valid), 64'(BYP));
        if (BYP) chk("fl_bypass_addr", 64'(fetch_entry[63:32]), 64'h8000_1000);
        drv(0, 0, 0, '0, 0);
        chk("fl_next_count", 64'(count), 64'd1);
        chk("fl_next_valid", 64'(fetch_valid), 64'd1);
        chk("fl_next_addr", 64'(fetch_entry[63:32]), 64'h8000_1000);
        drv(0, 0, 0, '0, 1);

`ifdef FETCH_FIFO_BYPASS_EN
        drv(0, 0, 1, {32'h8000_2000, 32'h0010_0093}, 1);
        chk("byp_valid", 64'(fetch_valid), 64'd1);
        chk("byp_entry", fetch_entry, {32'h8000_2000, 32'h0010_0093});
        drv(0, 0, 0, '0, 0);
        chk("byp_count", 64'(count), 64'd0);
        drv(0, 0, 1, {32'h8000_2000, 32'h0010_0093}, 0);
        chk("byp_stall_valid", 64'(fetch_valid), 64'd1);
        drv(0, 0, 0, '0, 0);
        chk("byp_stall_count", 64'(count), 64'd1);
        drv(0, 0, 0, '0, 1);
`endif

        // reset mid-operation clears storage as well as occupancy
        drv(0, 0, 1, w(400), 0);
        drv(0, 0, 1, w(401), 0);
        drv(1, 0, 1, w(402), 1);
        drv(0, 0, 0, '0, 0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_valid", 64'(fetch_valid), 64'd0);
        chk("rst_mid_entry", fetch_entry, 64'h0);

        for (int k = 0; k < 2000; k++)
            drv($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
                {$urandom, $urandom}, 1'($urandom));
        drv(0, 0, 0, '0, 0);
        @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
